// File: rtl/sr_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sr_cmd_sequencer: debounced set/reset requests -> guarded S/R pulses      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sr_cmd_sequencer #(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 3,
  parameter int CNT_W        = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SET_REQ,
  input  logic             RST_REQ,
  input  logic             Q_FB,
  output logic             S,
  output logic             R,
  output logic             BUSY,
  output logic             CONFLICT,
  output logic [CNT_W-1:0] CMD_CNT
);

  localparam int c_DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int c_PH_W   = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;

  localparam logic [c_DEB_W-1:0] c_DEB_LAST   = c_DEB_W'(DEB_CYCLES - 1);
  localparam logic [c_PH_W-1:0]  c_PULSE_LAST = c_PH_W'(PULSE_CYCLES - 1);
  localparam logic [c_PH_W-1:0]  c_GAP_LAST   = c_PH_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_PULSE = 2'd1;
  localparam logic [1:0] c_GAP   = 2'd2;

  logic [1:0]        w_raw;
  logic [1:0]        w_evt;
  logic              w_set_evt;
  logic              w_rst_evt;
  logic              w_take;
  logic              w_set_pend_nx;
  logic              w_rst_pend_nx;
  logic              w_conflict;

  logic [1:0]        r_state;
  logic [c_PH_W-1:0] r_ph;
  logic              r_s;
  logic              r_r;
  logic              r_busy;
  logic              r_conflict;
  logic              r_set_pend;
  logic              r_rst_pend;
  logic [CNT_W-1:0]  r_cmd_cnt;

  assign w_raw = {RST_REQ, SET_REQ};

  // Bit 0 is the set channel, bit 1 the reset channel.
  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic               r_sync1;
    logic               r_sync2;
    logic               r_deb;
    logic               r_evt;
    logic [c_DEB_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_deb   <= 1'b0;
        r_evt   <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
        r_evt   <= 1'b0;
        if (r_sync2 == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DEB_LAST) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
          r_evt <= r_sync2;
        end else begin
          r_cnt <= r_cnt + c_DEB_W'(1);
        end
      end
    end

    assign w_evt[gi] = r_evt;
  end

  assign w_set_evt = w_evt[0];
  assign w_rst_evt = w_evt[1];

  // Any pending flag is consumed in IDLE, whether or not it turns into a pulse.
  assign w_take = (r_state == c_IDLE);

  always_comb begin
    w_set_pend_nx = r_set_pend & ~w_take;
    w_rst_pend_nx = r_rst_pend & ~w_take;
    w_conflict    = 1'b0;
    if (w_set_evt && w_rst_evt) begin
      w_set_pend_nx = 1'b0;
      w_rst_pend_nx = 1'b0;
      w_conflict    = 1'b1;
    end else if (w_set_evt) begin
      w_conflict    = w_rst_pend_nx;
      w_set_pend_nx = 1'b1;
      w_rst_pend_nx = 1'b0;
    end else if (w_rst_evt) begin
      w_conflict    = w_set_pend_nx;
      w_rst_pend_nx = 1'b1;
      w_set_pend_nx = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_set_pend <= 1'b0;
      r_rst_pend <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_set_pend <= w_set_pend_nx;
      r_rst_pend <= w_rst_pend_nx;
      r_conflict <= w_conflict;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= c_IDLE;
      r_ph      <= '0;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_ph <= '0;
          // A request whose target already matches Q_FB is dropped silently.
          if (r_set_pend && !Q_FB) begin
            r_state   <= c_PULSE;
            r_s       <= 1'b1;
            r_busy    <= 1'b1;
            r_cmd_cnt <= r_cmd_cnt + CNT_W'(1);
          end else if (r_rst_pend && Q_FB) begin
            r_state   <= c_PULSE;
            r_r       <= 1'b1;
            r_busy    <= 1'b1;
            r_cmd_cnt <= r_cmd_cnt + CNT_W'(1);
          end
        end
        c_PULSE: begin
          if (r_ph == c_PULSE_LAST) begin
            r_s  <= 1'b0;
            r_r  <= 1'b0;
            r_ph <= '0;
            if (GAP_CYCLES == 0) begin
              r_state <= c_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= c_GAP;
            end
          end else begin
            r_ph <= r_ph + c_PH_W'(1);
          end
        end
        c_GAP: begin
          if (r_ph == c_GAP_LAST) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
            r_ph    <= '0;
          end else begin
            r_ph <= r_ph + c_PH_W'(1);
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_busy  <= 1'b0;
          r_ph    <= '0;
        end
      endcase
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign BUSY     = r_busy;
  assign CONFLICT = r_conflict;
  assign CMD_CNT  = r_cmd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_sequencer.sv
`default_nettype none
// Testbench for sr_cmd_sequencer: directed vector table plus multi-cycle sequences.
module tb_sr_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_req = 1'b0;
  logic       rst_req = 1'b0;
  logic       q_fb = 1'b0;
  logic       s, r, busy, conflict;
  logic [7:0] cmd_cnt;
  logic       s2, r2, busy2, conflict2;
  logic [1:0] cmd_cnt2;

  int checks = 0;
  int errors = 0;
  int tot_s = 0, tot_r = 0, tot_busy = 0, tot_conf = 0, overlap = 0;

  typedef struct {
    logic  set;
    logic  rst;
    logic  qfb;
    int    s_exp;
    int    r_exp;
    int    busy_exp;
    int    conf_exp;
    int    dcnt;
    string name;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  sr_cmd_sequencer u_dut (
    .CLK(clk), .RST_N(rst_n), .SET_REQ(set_req), .RST_REQ(rst_req), .Q_FB(q_fb),
    .S(s), .R(r), .BUSY(busy), .CONFLICT(conflict), .CMD_CNT(cmd_cnt)
  );

  sr_cmd_sequencer #(.CNT_W(2)) u_dut_w2 (
    .CLK(clk), .RST_N(rst_n), .SET_REQ(set_req), .RST_REQ(rst_req), .Q_FB(q_fb),
    .S(s2), .R(r2), .BUSY(busy2), .CONFLICT(conflict2), .CMD_CNT(cmd_cnt2)
  );

  always @(negedge clk) begin
    tot_s    <= tot_s + int'(s);
    tot_r    <= tot_r + int'(r);
    tot_busy <= tot_busy + int'(busy);
    tot_conf <= tot_conf + int'(conflict);
    if ((s & r) | (s2 & r2)) overlap <= overlap + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the requests long enough to debounce, issue and finish, then release and settle.
  task automatic run_cmd(input logic set, input logic rst, input logic qfb,
                         output int ds, output int dr, output int db, output int dc);
    int s0, r0, b0, c0;
    s0 = tot_s; r0 = tot_r; b0 = tot_busy; c0 = tot_conf;
    q_fb    = qfb;
    set_req = set;
    rst_req = rst;
    tick(20);
    set_req = 1'b0;
    rst_req = 1'b0;
    tick(20);
    ds = tot_s - s0; dr = tot_r - r0; db = tot_busy - b0; dc = tot_conf - c0;
  endtask

  initial begin
    int exp_cnt;
    int ds, dr, db, dc;
    int s0, r0, b0, c0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 2, 0, 5, 0, 1, "set_q0"};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 0, 2, 5, 0, 1, "rst_q1"};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, "set_q1_drop"};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, "rst_q0_drop"};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 0, "both_q0"};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 1, 0, "both_q1"};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, "quiet"};
    exp_cnt = 0;

    tick(3);
    check("rst_s", s, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    check("rst_conflict", conflict, 0);
    check("rst_cnt", cmd_cnt, 0);
    rst_n = 1'b1;
    tick(2);

    // Raw edge sampled at edge k: S high after k+7 and k+8, BUSY through k+11.
    q_fb    = 1'b0;
    set_req = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      #1;
      if (j >= 6 && j <= 9) check($sformatf("lat_s_k%0d", j), s, (j == 7 || j == 8) ? 1 : 0);
      if (j >= 10) check($sformatf("lat_busy_k%0d", j), busy, (j <= 11) ? 1 : 0);
      if (j == 7) check("lat_r", r, 0);
    end
    exp_cnt = 1;
    check("lat_cnt", cmd_cnt, 1);
    set_req = 1'b0;
    tick(20);

    // Three-cycle glitch never survives the debouncer.
    s0 = tot_s; b0 = tot_busy;
    set_req = 1'b1;
    tick(3);
    set_req = 1'b0;
    tick(20);
    check("glitch_s", tot_s - s0, 0);
    check("glitch_busy", tot_busy - b0, 0);
    check("glitch_cnt", cmd_cnt, exp_cnt);

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].set, vecs[i].rst, vecs[i].qfb, ds, dr, db, dc);
      exp_cnt += vecs[i].dcnt;
      check({vecs[i].name, "_s"}, ds, vecs[i].s_exp);
      check({vecs[i].name, "_r"}, dr, vecs[i].r_exp);
      check({vecs[i].name, "_busy"}, db, vecs[i].busy_exp);
      check({vecs[i].name, "_conf"}, dc, vecs[i].conf_exp);
      check({vecs[i].name, "_cnt"}, cmd_cnt, exp_cnt % 256);
      check({vecs[i].name, "_cnt_w2"}, cmd_cnt2, exp_cnt % 4);
    end

    // Reset request debounced during GAP: R after GAP plus one IDLE cycle (k+13, k+14).
    s0 = tot_s; r0 = tot_r; c0 = tot_conf;
    q_fb    = 1'b0;
    set_req = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk);
      #1;
      if (j == 3) rst_req = 1'b1;
      if (j == 8) q_fb = 1'b1;
      if (j >= 12 && j <= 15) check($sformatf("gap_r_k%0d", j), r, (j == 13 || j == 14) ? 1 : 0);
      if (j == 13) check("gap_s_k13", s, 0);
    end
    set_req = 1'b0;
    rst_req = 1'b0;
    tick(20);
    exp_cnt += 2;
    check("gap_s_total", tot_s - s0, 2);
    check("gap_r_total", tot_r - r0, 2);
    check("gap_conf", tot_conf - c0, 0);
    check("gap_cnt", cmd_cnt, exp_cnt % 256);

    // Asynchronous reset in the middle of an S pulse.
    q_fb    = 1'b0;
    set_req = 1'b1;
    @(posedge clk);
    tick(7);
    check("mid_s_before", s, 1);
    rst_n = 1'b0;
    #1;
    check("mid_s_drop", s, 0);
    check("mid_busy_drop", busy, 0);
    check("mid_cnt_clr", cmd_cnt, 0);
    check("mid_cnt_w2_clr", cmd_cnt2, 0);
    set_req = 1'b0;
    tick(3);
    rst_n = 1'b1;
    s0 = tot_s; r0 = tot_r;
    tick(20);
    check("post_rst_s", tot_s - s0, 0);
    check("post_rst_r", tot_r - r0, 0);
    check("post_rst_cnt", cmd_cnt, 0);
    exp_cnt = 0;

    // Four alternating commands: the 2-bit counter wraps 3 -> 0.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) run_cmd(1'b1, 1'b0, 1'b0, ds, dr, db, dc);
      else            run_cmd(1'b0, 1'b1, 1'b1, ds, dr, db, dc);
      exp_cnt++;
      check($sformatf("wrap_pulse_%0d", i), ds + dr, 2);
      check($sformatf("wrap_cnt_%0d", i), cmd_cnt, exp_cnt);
      check($sformatf("wrap_cnt_w2_%0d", i), cmd_cnt2, exp_cnt % 4);
    end

    check("s_and_r_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
